// File: rtl/mem_initiator.sv
// mem_initiator: valid/ready command front-end that sequences a synchronous 8x32 memory.
// Build option MEM_INITIATOR_VERIFY_EN adds a read-back check after every write beat.
module mem_initiator #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [ADDR_W-1:0] req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam int         CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

  // The VFY states are only reachable when the read-back option is built in.
  typedef enum logic [2:0] {
    S_IDLE, S_RD_ISSUE, S_RD_CAPTURE, S_WR_ISSUE, S_FILL, S_RESP, S_VFY_RD, S_VFY_CAP
  } state_t;

  state_t            r_state, w_state;
  logic              r_req_ready, w_req_ready;
  logic              r_rsp_valid, w_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata;
  logic              r_rsp_err, w_rsp_err;
  logic              r_mem_read, w_mem_read;
  logic              r_mem_write, w_mem_write;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic [ADDR_W-1:0] w_addr_inc;
  logic [CNT_W-1:0]  w_len_beats;
  logic              w_accept;
`ifdef MEM_INITIATOR_VERIFY_EN
  logic              r_is_fill, w_is_fill;
`endif

  assign w_addr_inc  = r_mem_addr + ADDR_W'(1);
  assign w_len_beats = (req_len == '0) ? CNT_FULL : {1'b0, req_len};
  assign w_accept    = req_valid && r_req_ready;

  always_comb begin
    w_state     = r_state;
    w_req_ready = r_req_ready;
    w_rsp_valid = r_rsp_valid;
    w_rsp_rdata = r_rsp_rdata;
    w_rsp_err   = r_rsp_err;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_cnt       = r_cnt;
`ifdef MEM_INITIATOR_VERIFY_EN
    w_is_fill   = r_is_fill;
`endif
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (w_accept) begin
          w_req_ready = 1'b0;
          w_rsp_rdata = '0;
          w_rsp_err   = 1'b0;
          case (req_op)
            OP_READ: begin
              w_mem_read = 1'b1;
              w_mem_addr = req_addr;
              w_state    = S_RD_ISSUE;
            end
            OP_WRITE: begin
              w_mem_write = 1'b1;
              w_mem_addr  = req_addr;
              w_mem_wdata = req_wdata;
              w_cnt       = CNT_ONE;
              w_state     = S_WR_ISSUE;
`ifdef MEM_INITIATOR_VERIFY_EN
              w_is_fill   = 1'b0;
`endif
            end
            OP_FILL: begin
              w_mem_write = 1'b1;
              w_mem_addr  = req_addr;
              w_mem_wdata = req_wdata;
              w_cnt       = w_len_beats;
              w_state     = S_FILL;
`ifdef MEM_INITIATOR_VERIFY_EN
              w_is_fill   = 1'b1;
`endif
            end
            default: begin
              // rsp_valid rises on the following edge from the RESP branch.
              w_rsp_err = 1'b1;
              w_state   = S_RESP;
            end
          endcase
        end
      end
      S_RD_ISSUE: w_state = S_RD_CAPTURE;
      S_RD_CAPTURE: begin
        w_rsp_rdata = mem_rdata;
        w_rsp_valid = 1'b1;
        w_state     = S_RESP;
      end
`ifdef MEM_INITIATOR_VERIFY_EN
      S_WR_ISSUE, S_FILL: begin
        w_mem_read = 1'b1;
        w_state    = S_VFY_RD;
      end
      S_VFY_RD: w_state = S_VFY_CAP;
      S_VFY_CAP: begin
        w_rsp_rdata = mem_rdata;
        if (mem_rdata != r_mem_wdata) w_rsp_err = 1'b1;
        if (r_is_fill && r_cnt != CNT_ONE) begin
          w_mem_write = 1'b1;
          w_mem_addr  = w_addr_inc;
          w_cnt       = r_cnt - CNT_ONE;
          w_state     = S_FILL;
        end else begin
          w_rsp_valid = 1'b1;
          w_state     = S_RESP;
        end
      end
`else
      S_WR_ISSUE: begin
        w_rsp_valid = 1'b1;
        w_state     = S_RESP;
      end
      S_FILL: begin
        if (r_cnt == CNT_ONE) begin
          w_rsp_valid = 1'b1;
          w_state     = S_RESP;
        end else begin
          w_mem_write = 1'b1;
          w_mem_addr  = w_addr_inc;
          w_cnt       = r_cnt - CNT_ONE;
        end
      end
`endif
      S_RESP: begin
        w_rsp_valid = 1'b1;
        if (r_rsp_valid && rsp_ready) begin
          w_rsp_valid = 1'b0;
          w_rsp_rdata = '0;
          w_rsp_err   = 1'b0;
          w_req_ready = 1'b1;
          w_state     = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cnt       <= '0;
`ifdef MEM_INITIATOR_VERIFY_EN
      r_is_fill   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state;
      r_req_ready <= w_req_ready;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_rdata <= w_rsp_rdata;
      r_rsp_err   <= w_rsp_err;
      r_mem_read  <= w_mem_read;
      r_mem_write <= w_mem_write;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_cnt       <= w_cnt;
`ifdef MEM_INITIATOR_VERIFY_EN
      r_is_fill   <= w_is_fill;
`endif
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_initiator.sv
// Scoreboard bench for mem_initiator with a behavioural synchronous 8x32 memory.
module tb_mem_initiator;
  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [4:0] req_addr;
  logic [7:0] req_wdata;
  logic [4:0] req_len;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       mem_read;
  logic       mem_write;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  mem_initiator #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: preloaded with 0x40+addr so untouched locations are recognisable.
  logic [7:0] mem [32];
  bit mem_init = 1'b1;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'(64 + i);
      mem_rdata <= 8'h00;
    end else begin
      if (mem_write) mem[mem_addr] <= mem_wdata;
      if (mem_read) mem_rdata <= mem[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         lat;
  } exp_t;
  exp_t expq[$];
  exp_t cur;
  bit   active = 1'b0;
  int   acc_cyc = 0;
  int   wlog_a[$];
  int   wlog_c[$];
  int   rd_cnt = 0;

  // Response monitor: pops the scoreboard on the first cycle of each response,
  // then holds that entry until the handshake to check stability.
  always @(negedge clk) begin
    if (reset) begin
      active = 1'b0;
    end else begin
      if (mem_read || mem_write) chk("rw_exclusive", 32'(mem_read & mem_write), 32'd0);
      if (mem_write) begin
        wlog_a.push_back(int'(mem_addr));
        wlog_c.push_back(cyc);
      end
      if (mem_read) rd_cnt++;
      if (req_valid && req_ready) acc_cyc = cyc + 1;
      if (rsp_valid) begin
        if (!active) begin
          if (expq.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
          end else begin
            cur = expq.pop_front();
            active = 1'b1;
            chk("rsp_latency", 32'(cyc - acc_cyc), 32'(cur.lat));
          end
        end
        if (active) begin
          chk("rsp_rdata", 32'(rsp_rdata), 32'(cur.rdata));
          chk("rsp_err", 32'(rsp_err), 32'(cur.err));
          chk("ready_in_resp", 32'(req_ready), 32'd0);
          chk("mem_idle_in_resp", 32'(mem_read | mem_write), 32'd0);
        end
        if (rsp_ready) active = 1'b0;
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [4:0] a, input logic [7:0] wd,
                      input logic [4:0] len, input bit push, input logic [7:0] er,
                      input logic ee, input int lat);
    bit ok = 1'b0;
    exp_t e;
    e.rdata = er; e.err = ee; e.lat = lat;
    if (push) expq.push_back(e);
    req_op = op; req_addr = a; req_wdata = wd; req_len = len; req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!ok) chk("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready && expq.size() == 0 && !active) begin ok = 1'b1; break; end
    end
    if (!ok) chk("idle_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] er);
    send(2'b00, a, 8'h00, 5'd0, 1'b1, er, 1'b0, 2);
    wait_idle();
  endtask

  initial begin
    int rd0;
    int exp_a[4] = '{30, 31, 0, 1};
    bit seen;
    reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = '0;
    req_wdata = '0; req_len = '0; rsp_ready = 1'b1;
    @(posedge clk); #1; mem_init = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_outputs", {rsp_valid, rsp_err, mem_read, mem_write, 3'b0, mem_addr, 8'h00, rsp_rdata, mem_wdata}, 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    // Single write then read-back.
    send(2'b01, 5'd5, 8'hA5, 5'd0, 1'b1, 8'h00, 1'b0, 1); wait_idle();
    rd(5'd5, 8'hA5);

    // Wrapping fill of 4 beats.
    wlog_a.delete(); wlog_c.delete(); rd0 = rd_cnt;
    send(2'b10, 5'd30, 8'h3C, 5'd4, 1'b1, 8'h00, 1'b0, 4); wait_idle();
    chk("fill4_beats", 32'(wlog_a.size()), 32'd4);
    chk("fill4_no_read", 32'(rd_cnt), 32'(rd0));
    for (int i = 0; i < 4 && i < wlog_a.size(); i++) begin
      chk("fill4_addr", 32'(wlog_a[i]), 32'(exp_a[i]));
      chk("fill4_consec", 32'(wlog_c[i] - wlog_c[0]), 32'(i));
    end
    for (int i = 0; i < 4; i++) rd(5'(exp_a[i]), 8'h3C);
    rd(5'd2, 8'h42);

    // len=0 means a full 32-beat fill.
    wlog_a.delete(); wlog_c.delete(); rd0 = rd_cnt;
    send(2'b10, 5'd0, 8'hFF, 5'd0, 1'b1, 8'h00, 1'b0, 32); wait_idle();
    chk("fill32_beats", 32'(wlog_a.size()), 32'd32);
    chk("fill32_no_read", 32'(rd_cnt), 32'(rd0));
    for (int i = 0; i < 32 && i < wlog_a.size(); i++) chk("fill32_addr", 32'(wlog_a[i]), 32'(i));
    for (int i = 0; i < 32; i++) rd(5'(i), 8'hFF);

    // Response backpressure: stall 5 cycles, accept on the 6th.
    rsp_ready = 1'b0;
    send(2'b00, 5'd7, 8'h00, 5'd0, 1'b1, 8'hFF, 1'b0, 2);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1'b1; break; end
    end
    chk("bp_rsp_seen", 32'(seen), 32'd1);
    repeat (4) @(negedge clk);
    chk("bp_valid_held", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1; rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("bp_ready_back", 32'(req_ready), 32'd1);
    chk("bp_valid_drop", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    wait_idle();

    // Illegal opcode: error response, no memory activity.
    wlog_a.delete(); rd0 = rd_cnt;
    send(2'b11, 5'd9, 8'h99, 5'd3, 1'b1, 8'h00, 1'b1, 1); wait_idle();
    chk("illegal_no_write", 32'(wlog_a.size()), 32'd0);
    chk("illegal_no_read", 32'(rd_cnt), 32'(rd0));

    // Reset during the 3rd beat of an 8-beat fill.
    send(2'b10, 5'd10, 8'h5A, 5'd8, 1'b0, 8'h00, 1'b0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_beat3_write", 32'(mem_write), 32'd1);
    chk("rst_beat3_addr", 32'(mem_addr), 32'd12);
    @(posedge clk); @(negedge clk);
    chk("rst_write_low", 32'(mem_write), 32'd0);
    chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
    chk("rst_ready_low", 32'(req_ready), 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_no_write", 32'(mem_write), 32'd0);
    @(posedge clk); #1;
    wait_idle();
    rd(5'd10, 8'h5A);
    rd(5'd11, 8'h5A);
    for (int i = 13; i <= 17; i++) rd(5'(i), 8'hFF);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
